odometer_readout_serializer: RTL and testbench

Reads out the stacked odometer's latched beat-frequency words and shifts them off-chip on a single scan line. Takes the concatenated 12-bit parallel outputs of NCH channel latches, safely snapshots them across the asynchronous DETECT domain, and shifts them out MSB-first on the scan clock. Daisy-chainable via SCAN_IN. Flags deadzone-saturated channels (all-ones words).

---
 rtl/odometer_readout_serializer.sv | 142 ++++++++++++++
 tb/tb_odometer_readout_serializer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/odometer_readout_serializer.sv
// Snapshots NCH x WIDTH odometer latch words and shifts them out MSB-first on SCLK.
// Optional even-parity trailer bit when ODO_READOUT_PARITY_EN is defined.
//
// state | meaning
// IDLE  | waiting for START rising edge
// SNAP  | re-sampling PARALLEL_IN until two samples agree or retries run out
// SHIFT | shifting frame out on SCAN_OUT, SCAN_IN fills vacated LSB
// DONE  | one-cycle FRAME_DONE, then back to IDLE
module odometer_readout_serializer #(
  parameter int NCH       = 4,
  parameter int WIDTH     = 12,
  parameter int MAX_RETRY = 3
) (
  input  logic                   SCLK,
  input  logic                   RESETB,
  input  logic                   START,
  input  logic [NCH*WIDTH-1:0]   PARALLEL_IN,
  input  logic                   SCAN_IN,
  output logic                   SCAN_OUT,
  output logic                   BUSY,
  output logic                   FRAME_DONE,
  output logic [NCH-1:0]         SAT_FLAGS,
  output logic                   UNSTABLE
);

  localparam int DATA_BITS = NCH * WIDTH;
`ifdef ODO_READOUT_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 1;
`else
  localparam int FRAME_BITS = DATA_BITS;
`endif
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic [RW-1:0] LAST_TRY = RW'(MAX_RETRY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SNAP, ST_SHIFT, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_BITS-1:0]    snap_q, snap_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]           bitcnt_q, bitcnt_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [NCH-1:0]          sat_q, sat_d;
  logic                    unst_q, unst_d;
  logic                    start_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    start_edge;
  logic                    snap_match;
  logic [NCH-1:0]          sat_calc;
  logic [FRAME_BITS-1:0]   frame_word;

  // On accept the live input equals snap_q when stable, or is the forced value otherwise.
  always_comb begin
    sat_calc = '0;
    for (int i = 0; i < NCH; i++) begin
      sat_calc[i] = &PARALLEL_IN[i*WIDTH +: WIDTH];
    end
`ifdef ODO_READOUT_PARITY_EN
    frame_word = {PARALLEL_IN, ^PARALLEL_IN};
`else
    frame_word = PARALLEL_IN;
`endif
  end

  assign start_edge = START & ~start_q;
  assign snap_match = (PARALLEL_IN == snap_q);

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    retry_d  = retry_q;
    sat_d    = sat_q;
    unst_d   = unst_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          snap_d  = PARALLEL_IN;
          retry_d = '0;
          unst_d  = 1'b0;
          state_d = ST_SNAP;
        end
      end
      ST_SNAP: begin
        if (snap_match || (retry_q == LAST_TRY)) begin
          shreg_d  = frame_word;
          sat_d    = sat_calc;
          bitcnt_d = '0;
          state_d  = ST_SHIFT;
          if (!snap_match) unst_d = 1'b1;
        end else begin
          snap_d  = PARALLEL_IN;
          retry_d = retry_q + RW'(1);
        end
      end
      ST_SHIFT: begin
        shreg_d  = {shreg_q[FRAME_BITS-2:0], SCAN_IN};
        bitcnt_d = bitcnt_q + CW'(1);
        if (bitcnt_q == LAST_BIT) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SCLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q  <= ST_IDLE;
      snap_q   <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      retry_q  <= '0;
      sat_q    <= '0;
      unst_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      retry_q  <= retry_d;
      sat_q    <= sat_d;
      unst_q   <= unst_d;
      start_q  <= START;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign SCAN_OUT   = shreg_q[FRAME_BITS-1];
  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;
  assign SAT_FLAGS  = sat_q;
  assign UNSTABLE   = unst_q;

endmodule

// File: tb/tb_odometer_readout_serializer.sv
// Bench for odometer_readout_serializer: queue-based frame model checked every cycle,
// plus directed frames with literal expectations. Honours ODO_READOUT_PARITY_EN.
module tb_odometer_readout_serializer;

  localparam int NCH = 4;
  localparam int WIDTH = 12;
  localparam int MAX_RETRY = 3;
  localparam int DW = NCH * WIDTH;
`ifdef ODO_READOUT_PARITY_EN
  localparam int FB = DW + 1;
`else
  localparam int FB = DW;
`endif

  logic SCLK = 1'b0;
  logic RESETB;
  logic START;
  logic [DW-1:0] PARALLEL_IN;
  logic SCAN_IN;
  logic SCAN_OUT;
  logic BUSY;
  logic FRAME_DONE;
  logic [NCH-1:0] SAT_FLAGS;
  logic UNSTABLE;

  int n_cmp = 0;
  int n_fail = 0;

  odometer_readout_serializer #(.NCH(NCH), .WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .SCLK(SCLK), .RESETB(RESETB), .START(START), .PARALLEL_IN(PARALLEL_IN),
    .SCAN_IN(SCAN_IN), .SCAN_OUT(SCAN_OUT), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
    .SAT_FLAGS(SAT_FLAGS), .UNSTABLE(UNSTABLE)
  );

  always #5 SCLK = ~SCLK;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: the shift register is a queue of pending output bits; the frame is pushed
  // whole on accept and each shift pops the head and appends SCAN_IN.
  bit             mq[$];
  int             m_mode = 0;   // 0 idle, 1 snapping, 2 shifting, 3 done
  logic [DW-1:0]  m_snap = '0;
  int             m_try = 0;
  int             m_rem = 0;
  logic           m_prev = 1'b0;
  logic [NCH-1:0] e_sat = '0;
  logic           e_unst = 1'b0, e_done = 1'b0, e_busy = 1'b0, e_out = 1'b0;

  always @(posedge SCLK) begin
    if (!RESETB) begin
      mq.delete();
      for (int b = 0; b < FB; b++) mq.push_back(1'b0);
      m_mode = 0; m_snap = '0; m_try = 0; m_rem = 0; m_prev = 1'b0;
      e_sat = '0; e_unst = 1'b0; e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      case (m_mode)
        0: if (START && !m_prev) begin
             m_snap = PARALLEL_IN; m_try = 0; e_unst = 1'b0; m_mode = 1;
           end
        1: if (PARALLEL_IN == m_snap || m_try == MAX_RETRY - 1) begin
             if (PARALLEL_IN != m_snap) e_unst = 1'b1;
             mq.delete();
             for (int b = DW - 1; b >= 0; b--) mq.push_back(PARALLEL_IN[b]);
`ifdef ODO_READOUT_PARITY_EN
             mq.push_back(bit'($countones(PARALLEL_IN) % 2));
`endif
             for (int c = 0; c < NCH; c++)
               e_sat[c] = (PARALLEL_IN[c*WIDTH +: WIDTH] == {WIDTH{1'b1}});
             m_rem = FB; m_mode = 2;
           end else begin
             m_snap = PARALLEL_IN; m_try++;
           end
        2: begin
             void'(mq.pop_front());
             mq.push_back(SCAN_IN);
             m_rem--;
             if (m_rem == 0) begin m_mode = 3; e_done = 1'b1; end
           end
        default: m_mode = 0;
      endcase
      m_prev = START;
    end
    e_busy = (m_mode != 0);
    e_out  = (mq.size() > 0) ? mq[0] : 1'b0;
  end

  always @(posedge SCLK) begin
    #2;
    chk("scan_out", SCAN_OUT, e_out);
    chk("busy", BUSY, e_busy);
    chk("frame_done", FRAME_DONE, e_done);
    chk("sat_flags", SAT_FLAGS, e_sat);
    chk("unstable", UNSTABLE, e_unst);
  end

  task automatic wait_done(input int bound, input bit rnd);
    int n = 0;
    bit seen = 0;
    while (n < bound && !seen) begin
      @(negedge SCLK);
      n++;
      if (FRAME_DONE) seen = 1;
      else if (rnd) begin
        SCAN_IN = 1'($urandom());
        START = ($urandom_range(0, 3) == 0);
      end
    end
    if (rnd) START = 1'b0;
    chk("frame_done_seen", seen, 1'b1);
  endtask

  task automatic capture_frame(input logic [DW-1:0] val, output logic [FB-1:0] bits);
    @(negedge SCLK);
    PARALLEL_IN = val; START = 1'b1; SCAN_IN = 1'b0;
    @(posedge SCLK);
    @(negedge SCLK);
    START = 1'b0;
    for (int k = 0; k < FB; k++) begin
      @(posedge SCLK);
      #2;
      bits[FB-1-k] = SCAN_OUT;
    end
    @(posedge SCLK);
    #2;
    chk("done_after_last_bit", FRAME_DONE, 1'b1);
    @(posedge SCLK);
    #2;
    chk("idle_after_done", BUSY, 1'b0);
  endtask

  task automatic rand_frame();
    logic [DW-1:0] v;
    int r;
    v = DW'({$urandom(), $urandom()});
    for (int c = 0; c < NCH; c++)
      if ($urandom_range(0, 3) == 0) v[c*WIDTH +: WIDTH] = {WIDTH{1'b1}};
    @(negedge SCLK);
    PARALLEL_IN = v; START = 1'b1; SCAN_IN = 1'($urandom());
    @(negedge SCLK);
    START = 1'b0;
    r = $urandom_range(0, 3);
    for (int j = 0; j < r; j++) begin
      PARALLEL_IN = PARALLEL_IN + DW'(1);
      @(negedge SCLK);
    end
    wait_done(FB + 12, 1'b1);
    repeat ($urandom_range(1, 3)) @(negedge SCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FB-1:0] bits;
    logic [DW-1:0] stable_val;
    int done_cnt;
`ifdef ODO_READOUT_PARITY_EN
    logic [FB-1:0] exp_bits;
`else
    logic [FB-1:0] exp_bits;
`endif

    RESETB = 1'b0; START = 1'b0; PARALLEL_IN = '0; SCAN_IN = 1'b0;
    repeat (3) @(negedge SCLK);
    chk("reset_scan_out", SCAN_OUT, 1'b0);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_sat", SAT_FLAGS, 4'b0000);
    RESETB = 1'b1;
    repeat (2) @(negedge SCLK);

    // Stable readout with known word ordering
    stable_val = {12'h00A, 12'h123, 12'h800, 12'h001};
    capture_frame(stable_val, bits);
`ifdef ODO_READOUT_PARITY_EN
    exp_bits = {48'h00A123800001, 1'b0};
`else
    exp_bits = 48'h00A123800001;
`endif
    chk("stable_frame_bits", bits, exp_bits);
    chk("stable_sat", SAT_FLAGS, 4'b0000);
    chk("stable_unstable", UNSTABLE, 1'b0);

    // Saturated channel 2
    capture_frame({12'h000, 12'hFFF, 12'h000, 12'h000}, bits);
    chk("sat_flags_ch2", SAT_FLAGS, 4'b0100);
    chk("sat_first_24", bits[FB-1 -: 24], 24'h000FFF);

`ifdef ODO_READOUT_PARITY_EN
    // Five data ones -> parity bit 1
    capture_frame({12'h000, 12'h007, 12'h000, 12'h003}, bits);
    chk("parity_bit", bits[0], 1'b1);
`endif

    // Input changing every cycle forces accept on the third compare
    @(negedge SCLK);
    PARALLEL_IN = 48'h123456789ABC; START = 1'b1; SCAN_IN = 1'b0;
    @(negedge SCLK); START = 1'b0; PARALLEL_IN = PARALLEL_IN + DW'(1);
    @(negedge SCLK); PARALLEL_IN = PARALLEL_IN + DW'(1);
    @(negedge SCLK); PARALLEL_IN = PARALLEL_IN + DW'(1);
    chk("unstable_still_snapping", UNSTABLE, 1'b0);
    chk("busy_in_snap", BUSY, 1'b1);
    @(posedge SCLK);
    #2;
    chk("unstable_flag", UNSTABLE, 1'b1);
    chk("unstable_first_bit", SCAN_OUT, 1'b0);
    @(negedge SCLK);
    chk("unstable_second_bit_shape", SCAN_OUT, 1'b0);
    wait_done(FB + 8, 1'b0);
    repeat (2) @(negedge SCLK);

    // Daisy chain: all-zero data, SCAN_IN=1, START held through DONE
    @(negedge SCLK);
    PARALLEL_IN = '0; SCAN_IN = 1'b1; START = 1'b1;
    wait_done(FB + 8, 1'b0);
    repeat (3) @(negedge SCLK);
    chk("daisy_all_ones", SCAN_OUT, 1'b1);
    chk("held_start_no_refire", BUSY, 1'b0);
    START = 1'b0;
    @(negedge SCLK);
    START = 1'b1;
    @(negedge SCLK);
    chk("restart_after_new_edge", BUSY, 1'b1);
    START = 1'b0; SCAN_IN = 1'b0;
    wait_done(FB + 8, 1'b0);
    repeat (2) @(negedge SCLK);

    // Reset mid-SHIFT
    @(negedge SCLK);
    PARALLEL_IN = {12'hFFF, 12'hFFF, 12'h0F0, 12'hFFF}; START = 1'b1; SCAN_IN = 1'b1;
    @(negedge SCLK); START = 1'b0;
    repeat (10) @(negedge SCLK);
    RESETB = 1'b0;
    #1;
    chk("rst_scan_out", SCAN_OUT, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_sat", SAT_FLAGS, 4'b0000);
    chk("rst_done", FRAME_DONE, 1'b0);
    chk("rst_unstable", UNSTABLE, 1'b0);
    repeat (2) @(negedge SCLK);
    RESETB = 1'b1;
    done_cnt = 0;
    repeat (60) begin
      @(negedge SCLK);
      if (FRAME_DONE) done_cnt++;
    end
    chk("no_done_after_reset", done_cnt, 0);

    // Randomized frames
    for (int f = 0; f < 30; f++) rand_frame();
    repeat (4) @(negedge SCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
